// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wrr_arb_pkg;

    // Arbiter FSM: IDLE picks a winner, BUSY holds it until the resource finishes.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WEIGHT_W = 4;

    // Widest weight field the helper below handles; callers zero-extend into it.
    localparam int WGT_MAX_W = 16;

    // A programmed weight of 0 would starve the requester forever, so it
    // behaves as a weight of 1.
    function automatic logic [WGT_MAX_W-1:0] eff_weight(input logic [WGT_MAX_W-1:0] w);
        return (w == '0) ? WGT_MAX_W'(1) : w;
    endfunction

endpackage

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Rotating-priority picker: first set mask bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs every cycle.
//
// Ports:
//   mask   : candidate requesters
//   ptr    : index with highest priority this cycle (must be < NUM_REQ)
//   onehot : one-hot winner (0 when mask is empty)
//   idx    : winner index (0 when mask is empty)
//   any    : mask had at least one set bit
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && mask[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter; a grant is held for a whole transaction until done.
// Latency: request seen in IDLE -> registered grant after the next clk edge (1 cycle).
// Backpressure: grant is held while BUSY regardless of req; new arbitration only after done.
//
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   req         : level request per requester
//   done        : one-cycle pulse, current transaction finished
//   cfg_weight  : weight of requester i at [i*WEIGHT_W +: WEIGHT_W] (0 acts as 1)
//   grant       : registered one-hot grant
//   grant_valid : OR of grant
//   grant_id    : index of the granted requester, 0 when idle
//   timeout_err : one-cycle pulse on watchdog release
//
// Build option WRR_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYC cycles; without it
// timeout_err is tied 0 and a grant is held until done indefinitely.
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic                         done,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  cfg_weight,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("wrr_burst_arbiter: NUM_REQ must be at least 2");
    end
    if (WEIGHT_W > WGT_MAX_W) begin : g_bad_weight_w
        $error("wrr_burst_arbiter: WEIGHT_W exceeds package limit");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("wrr_burst_arbiter: TIMEOUT_CYC must be at least 2");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  credit_q [NUM_REQ];
    logic [WEIGHT_W-1:0]  credit_d [NUM_REQ];
    logic [WEIGHT_W-1:0]  eff_w    [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic                 reload;
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [WEIGHT_W-1:0]  win_base;
    logic [WEIGHT_W-1:0]  win_left;
    logic [IDX_W-1:0]     next_idx;

    // Effective weights, recomputed live so a reload or reset picks up the
    // current configuration.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eff_w[i] = WEIGHT_W'(eff_weight(WGT_MAX_W'(cfg_weight[i*WEIGHT_W +: WEIGHT_W])));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] && (credit_q[i] != '0);
        end
    end

    // Every requesting master has spent its credit: start a new round in the
    // same cycle instead of burning an idle cycle on the reload.
    assign reload = (req != '0) && (eligible == '0);
    assign cand   = reload ? req : eligible;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .mask   (cand),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Winner's credit after this grant; on a reload it counts down from the
    // fresh weight rather than the stale (zero) credit.
    assign win_base = reload ? eff_w[pick_idx] : credit_q[pick_idx];
    assign win_left = win_base - WEIGHT_W'(1);
    assign next_idx = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

`ifdef WRR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
`ifdef WRR_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BUSY;
                    grant_d    = pick_onehot;
                    grant_id_d = pick_idx;
                    if (reload) begin
                        credit_d = eff_w;
                    end
                    credit_d[pick_idx] = win_left;
                    // Keep priority on the winner while it still has credit so it
                    // takes its weighted burst of consecutive wins.
                    ptr_d = (win_left != '0) ? pick_idx : next_idx;
`ifdef WRR_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (done) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
`ifdef WRR_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Stuck transaction: release and strip the offender's credit.
                    state_d              = IDLE;
                    grant_d              = '0;
                    grant_id_d           = '0;
                    timeout_d            = 1'b1;
                    credit_d[grant_id_q] = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            credit_q   <= eff_w;
`ifdef WRR_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
`ifdef WRR_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = grant_id_q;

`ifdef WRR_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: per-cycle vector table plus watchdog sequence.
// Latency: each row drives inputs, waits one clk edge, then checks registered outputs.
// Backpressure: n/a (bench).
module tb_wrr_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic        done;
    logic [15:0] cfg_weight;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wrr_burst_arbiter #(
        .NUM_REQ     (4),
        .WEIGHT_W    (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .cfg_weight  (cfg_weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        done;
        logic [15:0] cfg;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic [15:0] c, input logic [3:0] g, input logic [1:0] id);
        vec_t v;
        v.rst_n     = r;
        v.req       = rq;
        v.done      = d;
        v.cfg       = c;
        v.exp_grant = g;
        v.exp_id    = id;
        vecs.push_back(v);
    endfunction

    // One grant cycle followed by the done pulse that releases it.
    function automatic void gd(input logic [15:0] c, input logic [3:0] rq,
                               input logic [3:0] g, input logic [1:0] id);
        add(1'b1, rq, 1'b0, c, g, id);
        add(1'b1, rq, 1'b1, c, 4'b0000, 2'd0);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic step(input int row, input logic r, input logic [3:0] rq, input logic d,
                        input logic [15:0] c, input logic [3:0] g, input logic [1:0] id,
                        input logic terr);
        rst_n      = r;
        req        = rq;
        done       = d;
        cfg_weight = c;
        @(posedge clk);
        #1;
        chk("grant",       row, 32'(grant),       32'(g));
        chk("grant_valid", row, 32'(grant_valid), 32'(g != 4'b0000));
        chk("grant_id",    row, 32'(grant_id),    32'(id));
        chk("timeout_err", row, 32'(timeout_err), 32'(terr));
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req        = 4'b0000;
        done       = 1'b0;
        cfg_weight = 16'h1111;

        // Reset then idle, plus a stray done in IDLE that must be ignored.
        add(1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0);
        for (int k = 0; k < 10; k++) add(1'b1, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0);
        add(1'b1, 4'b0000, 1'b1, 16'h1111, 4'b0000, 2'd0);

        // Equal weights: plain rotation 0,1,2,3 then reload and 0 again.
        gd(16'h1111, 4'b1111, 4'b0001, 2'd0);
        gd(16'h1111, 4'b1111, 4'b0010, 2'd1);
        gd(16'h1111, 4'b1111, 4'b0100, 2'd2);
        gd(16'h1111, 4'b1111, 4'b1000, 2'd3);
        gd(16'h1111, 4'b1111, 4'b0001, 2'd0);

        // Weight 3 on requester 0: 0,0,0,1,2,3,0,0,0.
        add(1'b0, 4'b1111, 1'b0, 16'h1113, 4'b0000, 2'd0);
        for (int k = 0; k < 3; k++) gd(16'h1113, 4'b1111, 4'b0001, 2'd0);
        gd(16'h1113, 4'b1111, 4'b0010, 2'd1);
        gd(16'h1113, 4'b1111, 4'b0100, 2'd2);
        gd(16'h1113, 4'b1111, 4'b1000, 2'd3);
        for (int k = 0; k < 3; k++) gd(16'h1113, 4'b1111, 4'b0001, 2'd0);

        // Lone requester 2 with weight 2: reload must not add a stall cycle.
        add(1'b0, 4'b0100, 1'b0, 16'h1211, 4'b0000, 2'd0);
        for (int k = 0; k < 4; k++) gd(16'h1211, 4'b0100, 4'b0100, 2'd2);

        // Reset while BUSY drops the grant and restores credit 3 on requester 0.
        add(1'b0, 4'b1111, 1'b0, 16'h1113, 4'b0000, 2'd0);
        gd(16'h1113, 4'b1111, 4'b0001, 2'd0);
        add(1'b1, 4'b1111, 1'b0, 16'h1113, 4'b0001, 2'd0);
        add(1'b0, 4'b1111, 1'b0, 16'h1113, 4'b0000, 2'd0);
        for (int k = 0; k < 3; k++) gd(16'h1113, 4'b1111, 4'b0001, 2'd0);
        gd(16'h1113, 4'b1111, 4'b0010, 2'd1);

        // Grant held while req changes underneath; handover only after done.
        add(1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0);
        add(1'b1, 4'b0010, 1'b0, 16'h1111, 4'b0010, 2'd1);
        for (int k = 0; k < 3; k++) add(1'b1, 4'b1000, 1'b0, 16'h1111, 4'b0010, 2'd1);
        add(1'b1, 4'b1000, 1'b1, 16'h1111, 4'b0000, 2'd0);
        add(1'b1, 4'b1000, 1'b0, 16'h1111, 4'b1000, 2'd3);
        add(1'b1, 4'b1000, 1'b1, 16'h1111, 4'b0000, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].rst_n, vecs[i].req, vecs[i].done, vecs[i].cfg,
                 vecs[i].exp_grant, vecs[i].exp_id, 1'b0);
        end

        // Long transaction on requester 3 (weight 3) without done.
        step(1000, 1'b0, 4'b0000, 1'b0, 16'h3111, 4'b0000, 2'd0, 1'b0);
        step(1001, 1'b1, 4'b1000, 1'b0, 16'h3111, 4'b1000, 2'd3, 1'b0);
`ifdef WRR_TIMEOUT_EN
        // Eight BUSY cycles, then forced release with a one-cycle error pulse.
        for (int k = 0; k < 7; k++)
            step(1002 + k, 1'b1, 4'b1000, 1'b0, 16'h3111, 4'b1000, 2'd3, 1'b0);
        step(1009, 1'b1, 4'b1001, 1'b0, 16'h3111, 4'b0000, 2'd0, 1'b1);
        // Requester 3 lost its credit, so requester 0 wins despite ptr=3.
        step(1010, 1'b1, 4'b1001, 1'b0, 16'h3111, 4'b0001, 2'd0, 1'b0);
`else
        // No watchdog: the grant is held indefinitely until done.
        for (int k = 0; k < 20; k++)
            step(1002 + k, 1'b1, 4'b1000, 1'b0, 16'h3111, 4'b1000, 2'd3, 1'b0);
        step(1022, 1'b1, 4'b1001, 1'b1, 16'h3111, 4'b0000, 2'd0, 1'b0);
        // Requester 3 still has credit 2 and ptr=3, so it wins again.
        step(1023, 1'b1, 4'b1001, 1'b0, 16'h3111, 4'b1000, 2'd3, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter sharing one downstream resource between NUM_REQ requesters.
- A grant is held for a whole transaction, until the resource pulses done.
- Per-requester credits let a requester win up to its weight of consecutive arbitrations before priority rotates.
- Sits in front of the shared resource; its grant vector replaces a plain rotating-priority grant.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each weight/credit field.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with WRR_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req  input  NUM_REQ  level request per requester.
- done  input  1  one-cycle pulse from the resource: current transaction finished.
- cfg_weight  input  NUM_REQ*WEIGHT_W  weight of requester i in bits [i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
- grant  output  NUM_REQ  registered one-hot grant.
- grant_valid  output  1  OR of grant.
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.
- timeout_err  output  1  one-cycle pulse on forced release (WRR_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (rst_n low at a clk edge):
  - grant=0, grant_valid=0, grant_id=0, timeout_err=0.
  - state=IDLE, ptr=0.
  - credit[i]=eff_weight[i], where eff_weight = max(cfg_weight[i], 1).
  - Reset mid-transaction drops the grant on the next edge. No done is expected afterwards.
- FSM states: IDLE, BUSY.
- IDLE:
  - eligible = req & (credit!=0).
  - If req==0: stay in IDLE, no state change.
  - If req!=0 and eligible==0: the candidate mask is req, and all credits reload to eff_weight in this same cycle before the winner's decrement.
  - Otherwise the candidate mask is eligible.
  - Winner w = first set candidate bit scanning ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - At the next edge: grant=onehot(w), grant_id=w, credit[w] decremented by 1, state goes to BUSY.
  - ptr becomes w if credit[w] after the decrement is >0; otherwise (w+1) mod NUM_REQ.
- BUSY:
  - grant is held constant regardless of req; a requester dropping req does not release the grant.
  - done=1 at edge t: grant=0 and state=IDLE after edge t. The earliest new grant appears after edge t+1.
- Latency: req rising before edge t with the arbiter in IDLE gives grant after edge t (1 cycle).
- done while in IDLE is ignored.
- Credits are not modified in BUSY. A cfg_weight change takes effect only at the next reload or reset.
- grant is always one-hot or zero.

Optional Feature:
- Macro: WRR_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments every BUSY cycle.
  - When the counter reaches TIMEOUT_CYC-1 with done=0, the next edge forces BUSY->IDLE, clears grant and pulses timeout_err for one cycle.
  - done on the same edge wins: normal release, no timeout_err.
  - The granted requester loses all remaining credit.
- Undefined: no counter is implemented, timeout_err is constant 0, and a grant is held indefinitely until done.

Decomposition:
- Package wrr_arb_pkg:
  - state enum {IDLE, BUSY}.
  - default NUM_REQ/WEIGHT_W constants.
  - helper function eff_weight (0 maps to 1).
- Sub-module rr_pick:
  - purely combinational rotating-priority picker.
  - inputs: mask[NUM_REQ], ptr.
  - outputs: onehot, idx, any.
- Credits, ptr, FSM and the optional watchdog stay in the top module.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> grant=0, grant_valid=0, grant_id=0 throughout.
- All weights=1, req=4'b1111 held, done pulsed 1 cycle after each grant -> grant_id sequence 0,1,2,3,0; each grant 1 cycle after IDLE; 1 idle cycle between grants.
- Weights {w0=3, w1=1, w2=1, w3=1}, req=4'b1111 held, done on every grant -> grant_id sequence 0,0,0,1,2,3,0,0,0.
- Only req[2]=1 with weight 2, continuous done -> grants 2,2, then reload, then 2,2 with no stall cycle beyond the normal 1-cycle gap.
- In BUSY with grant_id=1, drop req[1] and raise req[3] -> grant stays 4'b0010 until done; after done, grant=4'b1000.
- Reset while BUSY -> grant=0 next edge, credits equal cfg_weight; with WRR_TIMEOUT_EN and TIMEOUT_CYC=8, no done -> grant cleared after 8 BUSY cycles with a 1-cycle timeout_err pulse.
